// File: rtl/ctrl_pipe.sv
// Pipeline control unit: decodes ID, carries controls through EX/MEM/WB,
// detects load-use hazards and selects operand forwarding for EX.
module ctrl_pipe #(
    parameter int unsigned EXT_OPS = 1,
    parameter int unsigned RA_W    = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [31:0]     id_instr,
    input  logic            stall_ext,
    input  logic            flush,
    output logic            id_stall,
    output logic            ex_valid,
    output logic            ex_branch,
    output logic            ex_jump,
    output logic            ex_lui,
    output logic            ex_alusrc,
    output logic [1:0]      ex_aluop,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    output logic            mem_valid,
    output logic            mem_read,
    output logic            mem_write,
    output logic            wb_valid,
    output logic            wb_regwrite,
    output logic            wb_memtoreg,
    output logic [RA_W-1:0] wb_rd,
    output logic            ex_illegal
);

    localparam logic [6:0] OpR    = 7'b0110011;
    localparam logic [6:0] OpLw   = 7'b0000011;
    localparam logic [6:0] OpSw   = 7'b0100011;
    localparam logic [6:0] OpBeq  = 7'b1100011;
    localparam logic [6:0] OpIalu = 7'b0010011;
    localparam logic [6:0] OpLui  = 7'b0110111;
    localparam logic [6:0] OpJal  = 7'b1101111;

    typedef struct packed {
        logic            valid;
        logic            illegal;
        logic            branch;
        logic            jump;
        logic            lui;
        logic            alusrc;
        logic [1:0]      aluop;
        logic            memread;
        logic            memtoreg;
        logic            memwrite;
        logic            regwrite;
        logic            rs2_use;
        logic [RA_W-1:0] rd;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
    } ex_t;

    typedef struct packed {
        logic            valid;
        logic            memread;
        logic            memwrite;
        logic            memtoreg;
        logic            regwrite;
        logic [RA_W-1:0] rd;
    } mem_t;

    typedef struct packed {
        logic            valid;
        logic            regwrite;
        logic            memtoreg;
        logic [RA_W-1:0] rd;
    } wb_t;

    ex_t  ex_q, ex_d, dec;
    mem_t mem_q, mem_d;
    wb_t  wb_q, wb_d;

    logic [6:0]      opcode;
    logic [RA_W-1:0] id_rd, id_rs1, id_rs2;
    logic            rs1_use;
    logic            load_use;
    logic            ext_en;
    logic            unused_fields;

    assign opcode        = id_instr[6:0];
    assign id_rd         = RA_W'(id_instr[11:7]);
    assign id_rs1        = RA_W'(id_instr[19:15]);
    assign id_rs2        = RA_W'(id_instr[24:20]);
    assign ext_en        = (EXT_OPS != 0);
    assign unused_fields = ^{id_instr[31:25], id_instr[14:12]};

    always_comb begin
        dec     = '0;
        rs1_use = 1'b0;
        if (id_valid) begin
            case (opcode)
                OpR: begin
                    dec.regwrite = 1'b1;
                    dec.aluop    = 2'b10;
                    rs1_use      = 1'b1;
                    dec.rs2_use  = 1'b1;
                end
                OpLw: begin
                    dec.memread  = 1'b1;
                    dec.memtoreg = 1'b1;
                    dec.alusrc   = 1'b1;
                    dec.regwrite = 1'b1;
                    rs1_use      = 1'b1;
                end
                OpSw: begin
                    dec.memwrite = 1'b1;
                    dec.alusrc   = 1'b1;
                    rs1_use      = 1'b1;
                    dec.rs2_use  = 1'b1;
                end
                OpBeq: begin
                    dec.branch  = 1'b1;
                    dec.aluop   = 2'b01;
                    rs1_use     = 1'b1;
                    dec.rs2_use = 1'b1;
                end
                OpIalu: begin
                    dec.alusrc   = ext_en;
                    dec.regwrite = ext_en;
                    dec.aluop    = ext_en ? 2'b11 : 2'b00;
                    rs1_use      = ext_en;
                    dec.illegal  = ~ext_en;
                end
                OpLui: begin
                    dec.lui      = ext_en;
                    dec.alusrc   = ext_en;
                    dec.regwrite = ext_en;
                    dec.illegal  = ~ext_en;
                end
                OpJal: begin
                    dec.jump     = ext_en;
                    dec.regwrite = ext_en;
                    dec.illegal  = ~ext_en;
                end
                default: dec.illegal = 1'b1;
            endcase
            if (!dec.illegal) begin
                dec.valid = 1'b1;
                dec.rd    = id_rd;
                dec.rs1   = id_rs1;
                dec.rs2   = id_rs2;
            end
            if (id_rd == '0) begin
                dec.regwrite = 1'b0;
            end
        end
    end

    assign load_use = ex_q.valid & ex_q.memread & (ex_q.rd != '0) & id_valid &
                      ((rs1_use & (ex_q.rd == id_rs1)) | (dec.rs2_use & (ex_q.rd == id_rs2)));

    assign id_stall = stall_ext | (load_use & ~flush);

    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (!stall_ext) begin
            wb_d.valid     = mem_q.valid;
            wb_d.regwrite  = mem_q.regwrite;
            wb_d.memtoreg  = mem_q.memtoreg;
            wb_d.rd        = mem_q.rd;
            mem_d.valid    = ex_q.valid;
            mem_d.memread  = ex_q.memread;
            mem_d.memwrite = ex_q.memwrite;
            mem_d.memtoreg = ex_q.memtoreg;
            mem_d.regwrite = ex_q.regwrite;
            mem_d.rd       = ex_q.rd;
            ex_d           = (flush || load_use) ? '0 : dec;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    // MEM result is newer than WB, so it wins when both match.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (mem_q.valid && mem_q.regwrite && (mem_q.rd != '0) && (mem_q.rd == ex_q.rs1)) begin
            fwd_a = 2'b10;
        end else if (wb_q.valid && wb_q.regwrite && (wb_q.rd != '0) && (wb_q.rd == ex_q.rs1)) begin
            fwd_a = 2'b01;
        end
        if (ex_q.rs2_use) begin
            if (mem_q.valid && mem_q.regwrite && (mem_q.rd != '0) &&
                (mem_q.rd == ex_q.rs2)) begin
                fwd_b = 2'b10;
            end else if (wb_q.valid && wb_q.regwrite && (wb_q.rd != '0) &&
                         (wb_q.rd == ex_q.rs2)) begin
                fwd_b = 2'b01;
            end
        end
    end

    assign ex_valid    = ex_q.valid;
    assign ex_branch   = ex_q.branch;
    assign ex_jump     = ex_q.jump;
    assign ex_lui      = ex_q.lui;
    assign ex_alusrc   = ex_q.alusrc;
    assign ex_aluop    = ex_q.aluop;
    assign ex_illegal  = ex_q.illegal;
    assign mem_valid   = mem_q.valid;
    assign mem_read    = mem_q.memread;
    assign mem_write   = mem_q.memwrite;
    assign wb_valid    = wb_q.valid;
    assign wb_regwrite = wb_q.regwrite;
    assign wb_memtoreg = wb_q.memtoreg;
    assign wb_rd       = wb_q.rd;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: stimulus pushes expected EX/MEM/WB records,
// a negedge monitor pops them as each stage presents a valid instruction.
module tb_ctrl_pipe;

    localparam logic [6:0] OpR    = 7'b0110011;
    localparam logic [6:0] OpLw   = 7'b0000011;
    localparam logic [6:0] OpSw   = 7'b0100011;
    localparam logic [6:0] OpBeq  = 7'b1100011;
    localparam logic [6:0] OpIalu = 7'b0010011;
    localparam logic [6:0] OpJal  = 7'b1101111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        id_valid = 1'b0;
    logic [31:0] id_instr = '0;
    logic        stall_ext = 1'b0;
    logic        flush = 1'b0;

    logic       id_stall, ex_valid, ex_branch, ex_jump, ex_lui, ex_alusrc, ex_illegal;
    logic [1:0] ex_aluop, fwd_a, fwd_b;
    logic       mem_valid, mem_read, mem_write, wb_valid, wb_regwrite, wb_memtoreg;
    logic [4:0] wb_rd;

    logic       id_stall_0, ex_valid_0, ex_branch_0, ex_jump_0, ex_lui_0, ex_alusrc_0;
    logic       ex_illegal_0;
    logic [1:0] ex_aluop_0, fwd_a_0, fwd_b_0;
    logic       mem_valid_0, mem_read_0, mem_write_0, wb_valid_0, wb_regwrite_0;
    logic       wb_memtoreg_0;
    logic [4:0] wb_rd_0;

    ctrl_pipe #(.EXT_OPS(1), .RA_W(5)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
        .stall_ext(stall_ext), .flush(flush), .id_stall(id_stall),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_lui(ex_lui),
        .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write),
        .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg),
        .wb_rd(wb_rd), .ex_illegal(ex_illegal)
    );

    ctrl_pipe #(.EXT_OPS(0), .RA_W(5)) dut0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
        .stall_ext(stall_ext), .flush(flush), .id_stall(id_stall_0),
        .ex_valid(ex_valid_0), .ex_branch(ex_branch_0), .ex_jump(ex_jump_0),
        .ex_lui(ex_lui_0), .ex_alusrc(ex_alusrc_0), .ex_aluop(ex_aluop_0),
        .fwd_a(fwd_a_0), .fwd_b(fwd_b_0), .mem_valid(mem_valid_0), .mem_read(mem_read_0),
        .mem_write(mem_write_0), .wb_valid(wb_valid_0), .wb_regwrite(wb_regwrite_0),
        .wb_memtoreg(wb_memtoreg_0), .wb_rd(wb_rd_0), .ex_illegal(ex_illegal_0)
    );

    logic [22:0] all_out;
    assign all_out = {ex_valid, ex_branch, ex_jump, ex_lui, ex_alusrc, ex_aluop, ex_illegal,
                      fwd_a, fwd_b, mem_valid, mem_read, mem_write, wb_valid, wb_regwrite,
                      wb_memtoreg, wb_rd};

    int errors = 0;
    int checks = 0;

    // EX record {branch,jump,lui,alusrc,aluop,fwd_a,fwd_b}; MEM {read,write};
    // WB {regwrite,memtoreg,rd}.
    logic [9:0] q_ex[$];
    logic [1:0] q_mem[$];
    logic [6:0] q_wb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: valid output with empty scoreboard at %0t", name, $time);
    endtask

    // A stage presents a new instruction only after an edge that was not frozen.
    logic adv = 1'b0;
    always @(posedge clk) adv <= !stall_ext && !rst;

    always @(negedge clk) begin
        if (adv) begin
            if (ex_valid) begin
                if (q_ex.size() == 0) unexpected("ex_unexpected");
                else check("ex_ctrl", 32'({ex_branch, ex_jump, ex_lui, ex_alusrc, ex_aluop,
                                            fwd_a, fwd_b}), 32'(q_ex.pop_front()));
            end
            if (mem_valid) begin
                if (q_mem.size() == 0) unexpected("mem_unexpected");
                else check("mem_ctrl", 32'({mem_read, mem_write}), 32'(q_mem.pop_front()));
            end
            if (wb_valid) begin
                if (q_wb.size() == 0) unexpected("wb_unexpected");
                else check("wb_ctrl", 32'({wb_regwrite, wb_memtoreg, wb_rd}),
                           32'(q_wb.pop_front()));
            end
        end
    end

    function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, op};
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, input logic fl,
                         input logic st, input logic rs);
        @(posedge clk);
        #1;
        id_valid  = v;
        id_instr  = ins;
        flush     = fl;
        stall_ext = st;
        rst       = rs;
        @(negedge clk);
    endtask

    task automatic nop();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic issue(input logic [31:0] ins, input logic [9:0] e, input logic [1:0] m,
                         input logic [6:0] w);
        q_ex.push_back(e);
        q_mem.push_back(m);
        q_wb.push_back(w);
        drive(1'b1, ins, 1'b0, 1'b0, 1'b0);
    endtask

    logic [31:0] add3, sub4, lw5, add6, addi6, lw0, add600, sw17, beq12, jal6, i3, lui8;

    initial begin
        add3   = enc(OpR, 5'd3, 5'd1, 5'd2);
        sub4   = enc(OpR, 5'd4, 5'd3, 5'd1);
        lw5    = enc(OpLw, 5'd5, 5'd1, 5'd0);
        add6   = enc(OpR, 5'd6, 5'd5, 5'd7);
        addi6  = enc(OpIalu, 5'd6, 5'd0, 5'd1);
        lw0    = enc(OpLw, 5'd0, 5'd1, 5'd0);
        add600 = enc(OpR, 5'd6, 5'd0, 5'd0);
        sw17   = enc(OpSw, 5'd0, 5'd1, 5'd7);
        beq12  = enc(OpBeq, 5'd0, 5'd1, 5'd2);
        jal6   = enc(OpJal, 5'd6, 5'd0, 5'd0);
        i3     = enc(OpR, 5'd6, 5'd4, 5'd3);
        lui8   = 32'h1234_5437;

        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        check("rst_outputs", 32'(all_out), 32'h0);
        nop();
        check("rst_id_stall", 32'(id_stall), 32'h0);

        // Back-to-back dependency forwards from MEM; one NOP apart from WB.
        issue(add3, 10'b0000_10_00_00, 2'b00, 7'b1_0_00011);
        issue(sub4, 10'b0000_10_10_00, 2'b00, 7'b1_0_00100);
        nop();
        issue(add3, 10'b0000_10_00_00, 2'b00, 7'b1_0_00011);
        nop();
        issue(sub4, 10'b0000_10_01_00, 2'b00, 7'b1_0_00100);
        nop();
        nop();

        issue(sw17, 10'b0001_00_00_00, 2'b01, 7'b0_0_00000);
        issue(beq12, 10'b1000_01_00_00, 2'b00, 7'b0_0_00000);
        issue(jal6, 10'b0100_00_00_00, 2'b00, 7'b1_0_00110);
        drive(1'b1, 32'h0000_007f, 1'b0, 1'b0, 1'b0);
        nop();
        check("illegal_flag", 32'(ex_illegal), 32'h1);
        check("illegal_bubble", 32'(ex_valid), 32'h0);
        nop();
        nop();

        // Load-use: one stall cycle, one bubble, then WB forwarding.
        issue(lw5, 10'b0001_00_00_00, 2'b10, 7'b1_1_00101);
        issue(add6, 10'b0000_10_01_00, 2'b00, 7'b1_0_00110);
        check("lu_stall", 32'(id_stall), 32'h1);
        drive(1'b1, add6, 1'b0, 1'b0, 1'b0);
        check("lu_one_cycle", 32'(id_stall), 32'h0);
        check("lu_bubble", 32'(ex_valid), 32'h0);
        nop();
        nop();
        nop();

        issue(lw5, 10'b0001_00_00_00, 2'b10, 7'b1_1_00101);
        issue(addi6, 10'b0001_11_00_00, 2'b00, 7'b1_0_00110);
        check("x0_src_nostall", 32'(id_stall), 32'h0);
        nop();
        nop();
        issue(lw0, 10'b0001_00_00_00, 2'b10, 7'b0_1_00000);
        issue(add600, 10'b0000_10_00_00, 2'b00, 7'b1_0_00110);
        check("x0_dst_nostall", 32'(id_stall), 32'h0);
        nop();
        nop();
        nop();

        // Flush wins over load-use: no stall, EX bubble, load still reaches MEM.
        issue(lw5, 10'b0001_00_00_00, 2'b10, 7'b1_1_00101);
        drive(1'b1, add6, 1'b1, 1'b0, 1'b0);
        check("flush_lu_nostall", 32'(id_stall), 32'h0);
        nop();
        check("flush_bubble", 32'(ex_valid), 32'h0);
        check("flush_lw_in_mem", 32'({mem_valid, mem_read}), 32'h3);
        nop();
        nop();

        // Full pipe frozen for 3 cycles; a flush during the freeze is ignored.
        issue(add3, 10'b0000_10_00_00, 2'b00, 7'b1_0_00011);
        issue(sub4, 10'b0000_10_10_00, 2'b00, 7'b1_0_00100);
        issue(i3, 10'b0000_10_10_01, 2'b00, 7'b1_0_00110);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, (i == 1), 1'b1, 1'b0);
            check("ext_stall", 32'(id_stall), 32'h1);
            check("ext_hold", 32'({ex_valid, ex_aluop, fwd_a, fwd_b, mem_valid, wb_valid, wb_rd}),
                  32'({1'b1, 2'b10, 2'b10, 2'b01, 1'b1, 1'b1, 5'd3}));
        end
        nop();
        nop();
        nop();
        nop();

        // Reset mid-stream overrides stall and flush and empties the pipe.
        q_ex.push_back(10'b0000_10_00_00);
        drive(1'b1, add3, 1'b0, 1'b0, 1'b0);
        drive(1'b1, sub4, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("midrst_outputs", 32'(all_out), 32'h0);
        check("midrst_id_stall", 32'(id_stall), 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        check("id_stall_follows_ext", 32'(id_stall), 32'h1);
        nop();
        nop();

        issue(lui8, 10'b0011_00_00_00, 2'b00, 7'b1_0_01000);
        nop();
        check("lui_ex", 32'({ex_lui, ex_alusrc}), 32'h3);
        check("ext0_illegal", 32'(ex_illegal_0), 32'h1);
        check("ext0_bubble", 32'(ex_valid_0), 32'h0);
        nop();
        nop();
        check("lui_wb_3cyc", 32'({wb_valid, wb_regwrite, wb_rd}), 32'({1'b1, 1'b1, 5'd8}));
        nop();
        nop();
        nop();

        check("q_ex_drained", 32'(q_ex.size()), 32'h0);
        check("q_mem_drained", 32'(q_mem.size()), 32'h0);
        check("q_wb_drained", 32'(q_wb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 SHALL have parameter EXT_OPS, default 1, meaning 1 enables I-ALU (0010011), LUI (0110111) and JAL (1101111) decode, and 0 decodes them as NOP.
REQ-002 SHALL have parameter RA_W, default 5, meaning register-address width.
REQ-003 SHALL have port clk input 1: sole clock, all state on rising edge.
REQ-004 SHALL have port rst input 1: reset, synchronous and active-high.
REQ-005 SHALL have port id_valid input 1: instruction in ID is valid.
REQ-006 SHALL have port id_instr input 32: ID instruction; opcode [6:0], rd [11:7], rs1 [19:15], rs2 [24:20].
REQ-007 SHALL have port stall_ext input 1: freeze the entire pipe, e.g. for a memory wait.
REQ-008 SHALL have port flush input 1: branch or jump taken in EX; kill the instruction in ID.
REQ-009 SHALL have port id_stall output 1: hold PC and IF/ID; combinational.
REQ-010 SHALL have ports ex_valid, ex_branch, ex_jump, ex_lui, ex_alusrc output 1 each: EX-stage controls.
REQ-011 SHALL have port ex_aluop output 2: EX ALU operation class.
REQ-012 SHALL have ports fwd_a, fwd_b output 2 each: operand forward select; 00 = regfile, 10 = MEM, 01 = WB.
REQ-013 SHALL have ports mem_valid, mem_read, mem_write output 1 each: MEM-stage controls.
REQ-014 SHALL have ports wb_valid, wb_regwrite, wb_memtoreg output 1 each, and port wb_rd output RA_W: WB-stage controls.
REQ-015 SHALL have port ex_illegal output 1: the EX-stage instruction has an undecodable opcode.

Function
REQ-016 SHALL decode {branch,memread,memtoreg,memwrite,alusrc,regwrite,aluop} as follows:
- R 0110011 = 0,0,0,0,0,1,10
- LW 0000011 = 0,1,1,0,1,1,00
- SW 0100011 = 0,0,0,1,1,0,00
- BEQ 1100011 = 1,0,0,0,0,0,01
REQ-017 SHALL decode, when EXT_OPS=1:
- I-ALU = alusrc,regwrite, aluop 11
- LUI = lui,alusrc,regwrite, aluop 00
- JAL = jump,regwrite, aluop 00
All other bits are 0.
REQ-018 SHALL treat any other opcode, or an EXT opcode with EXT_OPS=0, as a bubble: all controls 0, with the illegal bit set if id_valid.
REQ-019 SHALL force regwrite=0 when rd==0.
REQ-020 SHALL clear rs2-use for I-ALU, LW, LUI and JAL; rs1-use SHALL be 0 for LUI and JAL.
REQ-021 SHALL use three registered stages ID->EX->MEM->WB, each carrying valid, controls, rd, rs1 and rs2 as needed; controls appear on ex_* exactly 1 cycle after ID capture, mem_* after 2 and wb_* after 3.
REQ-022 SHALL define a bubble as valid=0 with every control bit 0 and rd 0.
REQ-023 SHALL compute load_use = ex_valid & mem_read-of-EX & ex_rd!=0 & id_valid & ((rs1-use & ex_rd==id_rs1) | (rs2-use & ex_rd==id_rs2)).
REQ-024 SHALL apply this per-edge priority: rst > stall_ext > flush > load_use > normal advance.
REQ-025 SHALL, when stall_ext=1, hold every stage register; flush and load_use have no effect.
REQ-026 SHALL, on flush (stall_ext=0), load a bubble into EX while MEM and WB advance normally.
REQ-027 SHALL, on load_use (no flush, no stall_ext), load a bubble into EX while MEM and WB advance, so the stall lasts exactly 1 cycle.
REQ-028 SHALL drive id_stall = stall_ext | (load_use & ~flush).
REQ-029 SHALL set fwd_a=10 if mem_valid & mem_regwrite & mem_rd!=0 & mem_rd==ex_rs1.
REQ-030 SHALL otherwise set fwd_a=01 if wb_valid & wb_regwrite & wb_rd!=0 & wb_rd==ex_rs1, else 00; MEM SHALL take priority over WB.
REQ-031 SHALL compute fwd_b identically against ex_rs2, and force it to 00 when the EX instruction does not use rs2.
REQ-032 SHALL make forwarding combinational from stage registers, with no combinational path from id_instr to any ex_*, mem_*, wb_* or fwd_* output.
REQ-033 SHALL not advance a stage with an invalid instruction as anything other than a bubble: a valid=0 input produces a bubble.

Reset
REQ-034 SHALL, on rst=1 at a clock edge, set every stage register to a bubble; all ex_*, mem_*, wb_*, ex_illegal and fwd_* outputs SHALL then be 0.
REQ-035 SHALL make a mid-operation rst discard all in-flight instructions, and rst SHALL override stall_ext and flush.
REQ-036 SHALL, after reset, have id_stall equal stall_ext.

Verification
REQ-037 SHALL cover: R add x3,x1,x2 then sub x4,x3,x1 back-to-back -> second in EX shows fwd_a=10; with one NOP between, fwd_a=01.
REQ-038 SHALL cover: LW x5 then add x6,x5,x7 -> id_stall=1 for exactly 1 cycle, one bubble (ex_valid=0), then fwd_a=01.
REQ-039 SHALL cover: LW x5 then I-ALU addi x6,x0,1 using rs1=x0 -> no stall; and LW x0 followed by a use of x0 -> no stall.
REQ-040 SHALL cover: flush and load_use in the same cycle -> id_stall=0 and EX bubble, with the older instruction reaching MEM.
REQ-041 SHALL cover: stall_ext=1 for 3 cycles with a full pipe -> all outputs unchanged, then resume in order; rst mid-stream -> all outputs 0 next cycle.
REQ-042 SHALL cover: EXT_OPS=0 with LUI -> bubble and ex_illegal=1; EXT_OPS=1 with LUI x8 -> ex_lui=1, ex_alusrc=1, and wb_regwrite=1 with wb_rd=8 three cycles later.
